// File: rtl/sdf_pkg.sv
// Shared types and constants for the serial divide-by-5 frame controller.
package sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [2:0] residue_t;

  localparam int DIVISOR = 5;

endpackage

// File: rtl/serial_mod5_core.sv
// Bit-serial mod-5 residue tracker: r <= (2r + b) mod 5 on each enabled cycle.
module serial_mod5_core
  import sdf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [2:0] residue
);

  residue_t    r_res;
  logic [3:0]  w_sum;
  residue_t    w_next;

  // 2r+b never exceeds 9, so a single conditional subtract closes the 5-state cycle.
  always_comb begin
    w_sum  = {r_res, bit_in};
    w_next = r_res;
    if (en) begin
      w_next = residue_t'((w_sum >= 4'(DIVISOR)) ? (w_sum - 4'(DIVISOR)) : w_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
    end else if (clr) begin
      r_res <= '0;
    end else begin
      r_res <= w_next;
    end
  end

  assign residue = r_res;

endmodule

// File: rtl/serial_div5_frame_ctrl.sv
// Frame controller: shifts words MSB-first into a mod-5 core and reports the frame residue.
// Optional macro SDF_DIV_CNT_EN adds the div_frames counter output.
module serial_div5_frame_ctrl
  import sdf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_div,
  output logic [2:0]       out_residue,
  output logic [7:0]       out_words
`ifdef SDF_DIV_CNT_EN
  ,
  output logic [15:0]      div_frames
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_last;
  logic [CNT_W-1:0] r_bitcnt;
  logic [7:0]       r_words;
  logic             r_out_valid;
  logic             r_out_div;
  residue_t         r_out_residue;
  logic [7:0]       r_out_words;

  logic             w_accept_in;
  logic             w_accept_out;
  logic             w_shift_en;
  residue_t         w_residue;

  assign w_accept_in  = in_valid && (r_state == IDLE);
  assign w_accept_out = r_out_valid && out_ready;
  assign w_shift_en   = (r_state == SHIFT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = SHIFT;
      SHIFT:   if (r_bitcnt == '0) w_next_state = r_last ? DONE : IDLE;
      DONE:    if (w_accept_out) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_last   <= 1'b0;
      r_bitcnt <= '0;
      r_words  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept_in) begin
        r_shreg  <= in_data;
        r_last   <= in_last;
        r_bitcnt <= CNT_W'(WIDTH - 1);
      end else if (w_shift_en) begin
        r_shreg  <= r_shreg << 1;
        r_bitcnt <= r_bitcnt - CNT_W'(1);
      end
      if (w_accept_out) begin
        r_words <= '0;
      end else if (w_accept_in && (r_words != 8'hFF)) begin
        r_words <= r_words + 8'd1;
      end
    end
  end

  // Result is snapshotted one cycle after entering DONE, so the fields stay frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_div     <= 1'b0;
      r_out_residue <= '0;
      r_out_words   <= '0;
    end else if (w_accept_out) begin
      r_out_valid   <= 1'b0;
      r_out_div     <= 1'b0;
      r_out_residue <= '0;
      r_out_words   <= '0;
    end else if ((r_state == DONE) && !r_out_valid) begin
      r_out_valid   <= 1'b1;
      r_out_div     <= (w_residue == '0);
      r_out_residue <= w_residue;
      r_out_words   <= r_words;
    end
  end

  serial_mod5_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_accept_out),
    .en      (w_shift_en),
    .bit_in  (r_shreg[WIDTH-1]),
    .residue (w_residue)
  );

`ifdef SDF_DIV_CNT_EN
  logic [15:0] r_div_frames;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_frames <= '0;
    end else if (w_accept_out && r_out_div) begin
      r_div_frames <= r_div_frames + 16'd1;
    end
  end

  assign div_frames = r_div_frames;
`endif

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out_div     = r_out_div;
  assign out_residue = r_out_residue;
  assign out_words   = r_out_words;

endmodule

// File: tb/tb_serial_div5_frame_ctrl.sv
// Self-checking bench for serial_div5_frame_ctrl against a whole-frame arithmetic model.
module tb_serial_div5_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic         out_div;
  logic [2:0]   out_residue;
  logic [7:0]   out_words;
`ifdef SDF_DIV_CNT_EN
  logic [15:0]  div_frames;
`endif

  int checks = 0;
  int errors = 0;
  int model_div_cnt = 0;
  logic [W-1:0] fr[$];

  always #5 clk = ~clk;

  serial_div5_frame_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_div     (out_div),
    .out_residue (out_residue),
    .out_words   (out_words)
`ifdef SDF_DIV_CNT_EN
    ,
    .div_frames  (div_frames)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake exclusivity is watched on every falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (!(in_ready && out_valid)) else begin
        errors++;
        $error("FAIL ready_valid_overlap: observed in_ready=%0b out_valid=%0b expected not both 1", in_ready, out_valid);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk({tag, " ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_frame(input string tag);
    for (int i = 0; i < fr.size(); i++) begin
      wait_ready(tag);
      in_valid = 1'b1;
      in_data  = fr[i];
      in_last  = (i == fr.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  // Reference: the frame is one big number, words concatenated MSB-first.
  task automatic collect(input string tag, input int bp);
    int          lat = 0;
    longint      r = 0;
    logic [2:0]  exp_res;
    logic [7:0]  exp_words;
    foreach (fr[k]) r = (r * (longint'(1) << W) + longint'(fr[k])) % 5;
    exp_res   = 3'(r);
    exp_words = (fr.size() > 255) ? 8'd255 : 8'(fr.size());
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), W + 1);
    chk({tag, " residue"}, 32'(out_residue), 32'(exp_res));
    chk({tag, " div"}, 32'(out_div), 32'(exp_res == 3'd0));
    chk({tag, " words"}, 32'(out_words), 32'(exp_words));
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_residue"}, 32'(out_residue), 32'(exp_res));
      chk({tag, " hold_words"}, 32'(out_words), 32'(exp_words));
      chk({tag, " hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " accepted_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " accepted_ready"}, 32'(in_ready), 32'd1);
    if (exp_res == 3'd0) model_div_cnt++;
  endtask

  task automatic run_frame(input string tag, input int bp);
    out_ready = (bp == 0);
    send_frame(tag);
    collect(tag, bp);
  endtask

  initial begin
    int stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_div", 32'(out_div), 32'd0);
    chk("reset out_residue", 32'(out_residue), 32'd0);
    chk("reset out_words", 32'(out_words), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    fr = '{8'd10};        run_frame("w10", 0);
    fr = '{8'd7};         run_frame("w7", 0);
    fr = '{8'd15};        run_frame("w15", 0);
    fr = '{8'd255};       run_frame("w255", 0);
    fr = '{8'h00, 8'h00}; run_frame("zeros", 0);
    fr = '{8'h01, 8'h00}; run_frame("v256", 0);
    fr = '{8'd42};        run_frame("backpressure", 5);

    // Reset three cycles into SHIFT must drop the frame.
    out_ready = 1'b1;
    wait_ready("rst_shift");
    in_valid = 1'b1; in_data = 8'd3; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_shift out_valid", 32'(out_valid), 32'd0);
    chk("rst_shift out_words", 32'(out_words), 32'd0);
    chk("rst_shift in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("rst_shift stale", 32'(stale), 32'd0);
    fr = '{8'd5}; run_frame("after_rst_shift", 0);

    // Reset while a result waits in DONE must drop the pending result.
    fr = '{8'd9, 8'd1};
    out_ready = 1'b0;
    send_frame("rst_done");
    stale = 0;
    while (!out_valid && stale < 100) begin
      @(posedge clk); #1;
      stale++;
    end
    chk("rst_done pending", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_done out_valid", 32'(out_valid), 32'd0);
    chk("rst_done out_residue", 32'(out_residue), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fr = '{8'd3}; run_frame("after_rst_done", 0);

    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 4);
      fr = {};
      for (int k = 0; k < n; k++) fr.push_back(W'($urandom));
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 3));
    end

    fr = {};
    for (int k = 0; k < 300; k++) fr.push_back(W'($urandom));
    run_frame("saturate", 0);

`ifdef SDF_DIV_CNT_EN
    chk("div_frames", 32'(div_frames), 32'(model_div_cnt[15:0]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_div5_frame_ctrl.md
SERIAL_DIV5_FRAME_CTRL -- requirements
Module: serial_div5_frame_ctrl

Interface
REQ-001 The block SHALL expose parameter: WIDTH, 8, bits per input word (legal range 2..32).
REQ-002 The block SHALL expose ports: clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  input word offered.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  WIDTH  word, shifted MSB first.
REQ-007 in_last  input  1  word is the final word of its frame.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 out_div  output  1  frame value divisible by 5.
REQ-011 out_residue  output  3  frame value mod 5 (0..4).
REQ-012 out_words  output  8  words in the frame, saturating at 255.

Function
REQ-013 The block SHALL run a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, capture in_data and in_last into a shift register, set bit counter to WIDTH-1, go to SHIFT.
REQ-015 SHIFT: in_ready=0; each cycle present the register MSB to the residue core, shift left, and decrement the counter; after WIDTH cycles, go to DONE if the captured last=1, else go to IDLE.
REQ-016 Residue update per bit b SHALL be r <= (2r + b) mod 5, starting from 0 at frame start.
REQ-017 Residue SHALL carry across words of one frame and clear only when a DONE result is accepted.
REQ-018 DONE: out_valid=1; out_residue=r; out_div=(r==0); out_words=frame word count; in_ready=0.
REQ-019 In DONE, outputs SHALL hold stable until out_valid&out_ready.
REQ-020 On acceptance, return to IDLE with residue and word count cleared.
REQ-021 Latency: out_valid SHALL rise WIDTH+1 rising edges after the edge accepting the last word.
REQ-022 Throughput: one word per WIDTH+1 cycles; in_ready and out_valid SHALL never both be 1.
REQ-023 Word count SHALL increment once per accepted word and saturate at 255 without wrapping.
REQ-024 A frame of all-zero words SHALL report residue 0, out_div=1.
REQ-025 in_data and in_last SHALL be ignored outside the accepting cycle.

Reset
REQ-026 While rst=1, regardless of clk: state=IDLE, residue=0, count=0, shift register=0, in_ready=1 after release, out_valid=0, out_div=0, out_residue=0, out_words=0.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL discard the partial or pending frame with no result emitted.

Configuration
REQ-028 Macro SDF_DIV_CNT_EN SHALL, when defined, add output div_frames (16 bits) counting accepted results with out_div=1, wrapping modulo 2^16, reset to 0.
REQ-029 When SDF_DIV_CNT_EN is undefined, port div_frames and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package sdf_pkg SHALL hold the FSM state enum (IDLE/SHIFT/DONE), the residue type (3 bits), and the constant DIVISOR=5.
REQ-031 Residue arithmetic SHALL live in sub-module serial_mod5_core (ports clk, rst, clr, en, bit_in, residue[2:0]): 5-state mod-5 FSM with residue=0 on reset or clr.
REQ-032 serial_div5_frame_ctrl SHALL instantiate exactly one serial_mod5_core.

Verification
REQ-033 Single word 8'd10, last=1, out_ready=1: out_valid after 9 edges; out_residue=0, out_div=1, out_words=1.
REQ-034 Single word 8'd7, last=1: out_residue=2, out_div=0; 8'd255: out_residue=0, out_div=1.
REQ-035 Two-word frame 8'h01 (last=0), then 8'h00 (last=1), value 256: out_residue=1, out_div=0, out_words=2.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE: out_valid and all fields stable, in_ready=0; result accepted on the first cycle out_ready=1, then in_ready=1.
REQ-037 Assert rst 3 cycles into SHIFT of 8'd3, release, then send 8'd5 last=1: out_residue=0, out_words=1, no stale result.
REQ-038 With SDF_DIV_CNT_EN: frames 10, 7, 15 give div_frames=2; build without the macro compiles with no div_frames port.
